// File: rtl/prga_fifo_resizer_up_pkg.sv
// Shared constants and helpers for the upsizing FIFO resizer.
// Holds no types; all widths are derived inside the modules.
package prga_fifo_resizer_up_pkg;

   // Word counter width; keeps at least one bit for the degenerate case.
   function automatic int cnt_w(input int ratio);
      return (ratio < 2) ? 1 : $clog2(ratio);
   endfunction

endpackage

// File: rtl/prga_fifo_resizer_up_if.sv
// Bundle of the upstream (narrow, lookahead) and downstream (wide) FIFO
// signals of the resizer. master = resizer side, slave = environment side.
//   empty_i/dout_i : upstream empty flag and data   (into resizer)
//   rd_i           : upstream read strobe           (from resizer)
//   empty/dout     : downstream empty flag and word (from resizer)
//   rd             : downstream read request        (into resizer)
interface prga_fifo_resizer_up_if #(
   parameter int DATA_WIDTH = 8,
   parameter int RATIO      = 4
);
   logic                            empty_i;
   logic                            rd_i;
   logic [DATA_WIDTH-1:0]           dout_i;
   logic                            empty;
   logic                            rd;
   logic [DATA_WIDTH*RATIO-1:0]     dout;

   modport master (
      input  empty_i, dout_i, rd,
      output rd_i, empty, dout
   );

   modport slave (
      output empty_i, dout_i, rd,
      input  rd_i, empty, dout
   );
endinterface

// File: rtl/prga_fifo_lookahead_buffer.sv
// Converts between lookahead and non-lookahead FIFO read semantics.
// REVERSED=0: non-lookahead source -> lookahead sink.
// REVERSED=1: lookahead source -> non-lookahead sink (data appears after rd).
// Ports: clk, rst (sync, active-high); empty_i/rd_i/dout_i source side;
//        empty/rd/dout sink side.
module prga_fifo_lookahead_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int REVERSED   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  empty_i,
   output logic                  rd_i,
   input  logic [DATA_WIDTH-1:0] dout_i,
   output logic                  empty,
   input  logic                  rd,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] dout_q, dout_d;

   if (REVERSED != 0) begin : g_rev
      assign rd_i  = rd & ~empty_i;
      assign empty = empty_i;

      // Capture the word being consumed; hold it until the next read.
      always_comb begin
         dout_d = dout_q;
         if (rd_i) dout_d = dout_i;
      end
   end else begin : g_fwd
      logic valid_q, valid_d;
      logic pend_q;

      assign empty = ~valid_q;
      // One read in flight at a time; its data lands one cycle later.
      assign rd_i  = ~rst & ~empty_i & ~pend_q & (~valid_q | rd);

      always_comb begin
         valid_d = valid_q;
         dout_d  = dout_q;
         if (rd & valid_q) valid_d = 1'b0;
         if (pend_q) begin
            valid_d = 1'b1;
            dout_d  = dout_i;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
         end else begin
            valid_q <= valid_d;
            pend_q  <= rd_i;
         end
      end
   end

   assign dout = dout_q;

   always_ff @(posedge clk) begin
      if (rst) dout_q <= '0;
      else     dout_q <= dout_d;
   end

endmodule

// File: rtl/prga_fifo_resizer_up.sv
// Packs RATIO narrow words from a lookahead FIFO into one wide word.
// Ports: clk, rst (sync, active-high); bus (master modport) carries
//        empty_i/rd_i/dout_i upstream and empty/rd/dout downstream.
module prga_fifo_resizer_up
   import prga_fifo_resizer_up_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int RATIO      = 4,
   parameter int LOOKAHEAD  = 0,
   parameter int LSB_FIRST  = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   prga_fifo_resizer_up_if.master bus
);

   localparam int            OW   = DATA_WIDTH * RATIO;
   localparam int            CW   = cnt_w(RATIO);
   localparam int            NC   = RATIO - 1;
   localparam logic [CW-1:0] LAST = CW'(NC);

   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] coll_q [NC];
   logic [DATA_WIDTH-1:0] coll_d [NC];
   logic [OW-1:0]         slot_q, slot_d;
   logic [OW-1:0]         packed_w;
   logic                  valid_q, valid_d;
   logic                  slot_empty;
   logic                  core_rd;
   logic                  not_last;
   logic                  consume;
   logic                  accept;

   assign slot_empty = ~valid_q;
   assign not_last   = (count_q != LAST);
   assign consume    = core_rd & valid_q;
   // The final word may only be taken if the slot is free by this edge.
   assign accept     = ~rst & ~bus.empty_i & (not_last | ~valid_q | consume);
   assign bus.rd_i   = accept;

   // Word k goes to lane k (LSB first) or lane RATIO-1-k (MSB first).
   always_comb begin
      packed_w = '0;
      for (int k = 0; k < NC; k++) begin
         packed_w[((LSB_FIRST != 0) ? k : NC - k) * DATA_WIDTH +: DATA_WIDTH]
            = coll_q[k];
      end
      packed_w[((LSB_FIRST != 0) ? NC : 0) * DATA_WIDTH +: DATA_WIDTH]
         = bus.dout_i;
   end

   always_comb begin
      count_d = count_q;
      coll_d  = coll_q;
      slot_d  = slot_q;
      valid_d = valid_q;
      if (consume) valid_d = 1'b0;
      if (accept) begin
         if (not_last) begin
            for (int i = 0; i < NC; i++) begin
               if (count_q == CW'(i)) coll_d[i] = bus.dout_i;
            end
            count_d = count_q + CW'(1);
         end else begin
            slot_d  = packed_w;
            valid_d = 1'b1;
            count_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         coll_q  <= '{default: '0};
         slot_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         count_q <= count_d;
         coll_q  <= coll_d;
         slot_q  <= slot_d;
         valid_q <= valid_d;
      end
   end

   if (LOOKAHEAD != 0) begin : g_la
      assign bus.empty = slot_empty;
      assign bus.dout  = slot_q;
      assign core_rd   = bus.rd;
   end else begin : g_nla
      prga_fifo_lookahead_buffer #(
         .DATA_WIDTH (OW),
         .REVERSED   (1)
      ) u_buf (
         .clk     (clk),
         .rst     (rst),
         .empty_i (slot_empty),
         .rd_i    (core_rd),
         .dout_i  (slot_q),
         .empty   (bus.empty),
         .rd      (bus.rd),
         .dout    (bus.dout)
      );
   end

endmodule

// File: tb/tb_prga_fifo_resizer_up.sv
// Directed bench for prga_fifo_resizer_up over four configurations:
// LA/LSB, LA/MSB, non-LA/LSB (random reads), LA RATIO=3.
module tb_prga_fifo_resizer_up;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic        emp_i_v [4];
   logic [7:0]  din_v   [4];
   logic        rd_v    [4];
   logic        rdi_w   [4];
   logic        emp_w   [4];
   logic [31:0] dout_w  [4];
   logic [7:0]  src     [4][$];
   logic        take    [4];
   logic        acc     [4];

   logic [7:0]  bytes_r [256];
   logic [31:0] golden  [64];

   prga_fifo_resizer_up_if #(.DATA_WIDTH(8), .RATIO(4)) if0 ();
   prga_fifo_resizer_up_if #(.DATA_WIDTH(8), .RATIO(4)) if1 ();
   prga_fifo_resizer_up_if #(.DATA_WIDTH(8), .RATIO(4)) if2 ();
   prga_fifo_resizer_up_if #(.DATA_WIDTH(8), .RATIO(3)) if3 ();

   assign if0.empty_i = emp_i_v[0];
   assign if0.dout_i  = din_v[0];
   assign if0.rd      = rd_v[0];
   assign rdi_w[0]    = if0.rd_i;
   assign emp_w[0]    = if0.empty;
   assign dout_w[0]   = if0.dout;

   assign if1.empty_i = emp_i_v[1];
   assign if1.dout_i  = din_v[1];
   assign if1.rd      = rd_v[1];
   assign rdi_w[1]    = if1.rd_i;
   assign emp_w[1]    = if1.empty;
   assign dout_w[1]   = if1.dout;

   assign if2.empty_i = emp_i_v[2];
   assign if2.dout_i  = din_v[2];
   assign if2.rd      = rd_v[2];
   assign rdi_w[2]    = if2.rd_i;
   assign emp_w[2]    = if2.empty;
   assign dout_w[2]   = if2.dout;

   assign if3.empty_i = emp_i_v[3];
   assign if3.dout_i  = din_v[3];
   assign if3.rd      = rd_v[3];
   assign rdi_w[3]    = if3.rd_i;
   assign emp_w[3]    = if3.empty;
   assign dout_w[3]   = {8'h00, if3.dout};

   prga_fifo_resizer_up #(
      .DATA_WIDTH(8), .RATIO(4), .LOOKAHEAD(1), .LSB_FIRST(1)
   ) u_la (.clk(clk), .rst(rst), .bus(if0.master));

   prga_fifo_resizer_up #(
      .DATA_WIDTH(8), .RATIO(4), .LOOKAHEAD(1), .LSB_FIRST(0)
   ) u_msb (.clk(clk), .rst(rst), .bus(if1.master));

   prga_fifo_resizer_up #(
      .DATA_WIDTH(8), .RATIO(4), .LOOKAHEAD(0), .LSB_FIRST(1)
   ) u_nla (.clk(clk), .rst(rst), .bus(if2.master));

   prga_fifo_resizer_up #(
      .DATA_WIDTH(8), .RATIO(3), .LOOKAHEAD(1), .LSB_FIRST(1)
   ) u_r3 (.clk(clk), .rst(rst), .bus(if3.master));

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic refresh();
      for (int i = 0; i < 4; i++) begin
         emp_i_v[i] = (src[i].size() == 0);
         din_v[i]   = (src[i].size() == 0) ? 8'h00 : src[i][0];
      end
   endtask

   task automatic push(input int i, input logic [7:0] b);
      src[i].push_back(b);
      refresh();
   endtask

   // One clock: sample handshakes mid-cycle, then pop consumed bytes.
   task automatic step();
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check("rdi_while_empty", {31'd0, rdi_w[i] & emp_i_v[i]}, 32'd0);
         take[i] = rdi_w[i] & ~emp_i_v[i];
         acc[i]  = rd_v[i] & ~emp_w[i];
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (take[i] && src[i].size() > 0) void'(src[i].pop_front());
      end
      refresh();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         src[i].delete();
         rd_v[i] = 1'b0;
      end
      refresh();
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      int idx;
      int cyc;
      logic [31:0] held;
      logic [7:0]  r3_in [9];
      logic        r3_emp [9];
      logic [31:0] r3_word [3];

      for (int i = 0; i < 4; i++) rd_v[i] = 1'b0;
      refresh();

      // Reset state, with upstream data pending to prove rd_i is held low.
      rst = 1'b1;
      push(0, 8'h5A); push(0, 8'hF6); push(0, 8'h09); push(0, 8'hC4);
      push(1, 8'h5A); push(1, 8'hF6); push(1, 8'h09); push(1, 8'hC4);
      step();
      step();
      check("rst_rd_i",  {31'd0, rdi_w[0]}, 32'd0);
      check("rst_empty", {31'd0, emp_w[0]}, 32'd1);
      check("rst_dout",  dout_w[0], 32'h0);
      check("rst_empty_nla", {31'd0, emp_w[2]}, 32'd1);
      check("rst_dout_nla",  dout_w[2], 32'h0);

      // Basic pack, LSB and MSB first, rd held high.
      rd_v[0] = 1'b1;
      rd_v[1] = 1'b1;
      rst = 1'b0;
      step(); step(); step();
      check("la_partial_empty", {31'd0, emp_w[0]}, 32'd1);
      step();
      check("la_lsb_empty", {31'd0, emp_w[0]}, 32'd0);
      check("la_lsb_dout",  dout_w[0], 32'hC409F65A);
      check("la_msb_empty", {31'd0, emp_w[1]}, 32'd0);
      check("la_msb_dout",  dout_w[1], 32'h5AF609C4);
      step();
      check("la_consumed_empty", {31'd0, emp_w[0]}, 32'd1);

      // Backpressure: rd held low, collector fills then stalls upstream.
      do_reset();
      push(0, 8'h5A); push(0, 8'hF6); push(0, 8'h09); push(0, 8'hC4);
      push(0, 8'h81); push(0, 8'hE2); push(0, 8'hA0); push(0, 8'h7A);
      for (int n = 0; n < 10; n++) step();
      check("bp_rd_i_low",  {31'd0, rdi_w[0]}, 32'd0);
      check("bp_left",      src[0].size(), 32'd1);
      check("bp_dout_held", dout_w[0], 32'hC409F65A);
      check("bp_empty",     {31'd0, emp_w[0]}, 32'd0);
      rd_v[0] = 1'b1;
      #1;
      check("bp_rd_i_release", {31'd0, rdi_w[0]}, 32'd1);
      step();
      check("bp_word2",      dout_w[0], 32'h7AA0E281);
      check("bp_word2_empty", {31'd0, emp_w[0]}, 32'd0);
      check("bp_drained",    src[0].size(), 32'd0);
      step();
      check("bp_end_empty",  {31'd0, emp_w[0]}, 32'd1);

      // Reset in the middle of a word discards the partial collection.
      do_reset();
      rd_v[0] = 1'b1;
      push(0, 8'h11); push(0, 8'h22); push(0, 8'h33); push(0, 8'h44);
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_empty", {31'd0, emp_w[0]}, 32'd1);
      check("mid_rst_left",  src[0].size(), 32'd2);
      check("mid_rst_dout",  dout_w[0], 32'h0);
      push(0, 8'h55); push(0, 8'h66);
      step(); step(); step();
      check("mid_rst_partial", {31'd0, emp_w[0]}, 32'd1);
      step();
      check("mid_rst_word_empty", {31'd0, emp_w[0]}, 32'd0);
      check("mid_rst_word", dout_w[0], 32'h66554433);

      // RATIO=3: one word every third cycle with continuous input.
      do_reset();
      rd_v[3] = 1'b1;
      r3_in   = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                  8'h06, 8'h07, 8'h08, 8'h09};
      r3_emp  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      r3_word = '{32'h00030201, 32'h00060504, 32'h00090807};
      for (int n = 0; n < 9; n++) push(3, r3_in[n]);
      for (int n = 0; n < 9; n++) begin
         step();
         check("r3_empty", {31'd0, emp_w[3]}, {31'd0, r3_emp[n]});
         if (n % 3 == 2) check("r3_word", dout_w[3], r3_word[n / 3]);
      end

      // Non-lookahead output with random reads over 256 random bytes.
      do_reset();
      for (int n = 0; n < 256; n++) bytes_r[n] = 8'($urandom_range(0, 255));
      for (int w = 0; w < 64; w++) begin
         golden[w] = {bytes_r[4*w+3], bytes_r[4*w+2],
                      bytes_r[4*w+1], bytes_r[4*w]};
      end
      for (int n = 0; n < 256; n++) src[2].push_back(bytes_r[n]);
      refresh();
      idx = 0;
      cyc = 0;
      while (idx < 64 && cyc < 4000) begin
         rd_v[2] = 1'($urandom_range(0, 1));
         held    = (idx == 0) ? 32'h0 : golden[idx-1];
         step();
         if (acc[2]) begin
            check("nla_word", dout_w[2], golden[idx]);
            idx++;
         end else begin
            check("nla_hold", dout_w[2], held);
         end
         cyc++;
      end
      check("nla_all_words", idx, 32'd64);
      rd_v[2] = 1'b1;
      step();
      step();
      check("nla_end_empty", {31'd0, emp_w[2]}, 32'd1);
      check("nla_end_hold",  dout_w[2], golden[63]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
